// File: rtl/alu_flag_ir_unit_if.sv
// Bus bundle between the control/datapath side and the ALU/flag/IR slice.
// clk and reset are not in the bundle; they stay plain ports on the unit.
interface alu_flag_ir_unit_if #(
   parameter int WIDTH = 32
);
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic [4:0]       op;
   logic             carry_in;
   logic             FRLd;
   logic             IRLd;
   logic [WIDTH-1:0] ir_in;
   logic [WIDTH-1:0] result;
   logic             flag_n;
   logic             flag_z;
   logic             flag_c;
   logic             flag_v;
   logic [3:0]       fdr_q;
   logic [WIDTH-1:0] ir_q;

   modport master (
      output A, B, op, carry_in, FRLd, IRLd, ir_in,
      input  result, flag_n, flag_z, flag_c, flag_v, fdr_q, ir_q
   );

   modport slave (
      input  A, B, op, carry_in, FRLd, IRLd, ir_in,
      output result, flag_n, flag_z, flag_c, flag_v, fdr_q, ir_q
   );
endinterface

// File: rtl/alu_flag_ir_unit.sv
// Execution slice: combinational ALU with NZCV flags, a 4-bit flag register
// and the instruction register.
module alu_flag_ir_unit #(
   parameter int WIDTH = 32
) (
   input  logic              CLK,
   input  logic              CLR,
   alu_flag_ir_unit_if.slave bus
);
   localparam logic [4:0] OP_AND  = 5'b00000;
   localparam logic [4:0] OP_EOR  = 5'b00001;
   localparam logic [4:0] OP_SUB  = 5'b00010;
   localparam logic [4:0] OP_RSB  = 5'b00011;
   localparam logic [4:0] OP_ADD  = 5'b00100;
   localparam logic [4:0] OP_ADC  = 5'b00101;
   localparam logic [4:0] OP_SBC  = 5'b00110;
   localparam logic [4:0] OP_RSC  = 5'b00111;
   localparam logic [4:0] OP_TST  = 5'b01000;
   localparam logic [4:0] OP_TEQ  = 5'b01001;
   localparam logic [4:0] OP_CMP  = 5'b01010;
   localparam logic [4:0] OP_CMN  = 5'b01011;
   localparam logic [4:0] OP_ORR  = 5'b01100;
   localparam logic [4:0] OP_MOV  = 5'b01101;
   localparam logic [4:0] OP_BIC  = 5'b01110;
   localparam logic [4:0] OP_MVN  = 5'b01111;
   localparam logic [4:0] OP_PASS = 5'b10000;
   localparam logic [4:0] OP_AP4  = 5'b10001;
   localparam logic [4:0] OP_BP4  = 5'b10010;
   localparam logic [4:0] OP_AM4  = 5'b10011;

   localparam logic [WIDTH-1:0] FOUR = WIDTH'(4);

   logic [WIDTH-1:0] add_x;
   logic [WIDTH-1:0] add_y;
   logic             add_cin;
   logic             is_arith;
   logic [WIDTH-1:0] logic_res;
   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] alu_res;
   logic             alu_n;
   logic             alu_z;
   logic             alu_c;
   logic             alu_v;

   logic [3:0]       fdr_q;
   logic [3:0]       fdr_d;
   logic [WIDTH-1:0] ir_q;
   logic [WIDTH-1:0] ir_d;

   // Every arithmetic op goes through one adder: subtraction is x + ~y + cin,
   // so the adder carry-out is directly the "no borrow" C flag.
   always_comb begin
      add_x     = '0;
      add_y     = '0;
      add_cin   = 1'b0;
      is_arith  = 1'b0;
      logic_res = '0;
      case (bus.op)
         OP_AND, OP_TST: logic_res = bus.A & bus.B;
         OP_EOR, OP_TEQ: logic_res = bus.A ^ bus.B;
         OP_ORR:         logic_res = bus.A | bus.B;
         OP_MOV:         logic_res = bus.B;
         OP_BIC:         logic_res = bus.A & ~bus.B;
         OP_MVN:         logic_res = ~bus.B;
         OP_PASS:        logic_res = bus.A;
         OP_SUB, OP_CMP: begin
            add_x    = bus.A;
            add_y    = ~bus.B;
            add_cin  = 1'b1;
            is_arith = 1'b1;
         end
         OP_RSB: begin
            add_x    = bus.B;
            add_y    = ~bus.A;
            add_cin  = 1'b1;
            is_arith = 1'b1;
         end
         OP_ADD, OP_CMN: begin
            add_x    = bus.A;
            add_y    = bus.B;
            is_arith = 1'b1;
         end
         OP_ADC: begin
            add_x    = bus.A;
            add_y    = bus.B;
            add_cin  = bus.carry_in;
            is_arith = 1'b1;
         end
         OP_SBC: begin
            add_x    = bus.A;
            add_y    = ~bus.B;
            add_cin  = bus.carry_in;
            is_arith = 1'b1;
         end
         OP_RSC: begin
            add_x    = bus.B;
            add_y    = ~bus.A;
            add_cin  = bus.carry_in;
            is_arith = 1'b1;
         end
         OP_AP4: begin
            add_x    = bus.A;
            add_y    = FOUR;
            is_arith = 1'b1;
         end
         OP_BP4: begin
            add_x    = bus.B;
            add_y    = FOUR;
            is_arith = 1'b1;
         end
         OP_AM4: begin
            add_x    = bus.A;
            add_y    = ~FOUR;
            add_cin  = 1'b1;
            is_arith = 1'b1;
         end
         default: logic_res = '0;
      endcase
   end

   assign sum     = {1'b0, add_x} + {1'b0, add_y} + {{WIDTH{1'b0}}, add_cin};
   assign alu_res = is_arith ? sum[WIDTH-1:0] : logic_res;

   // Overflow on the adder inputs also covers subtraction because the
   // subtrahend arrives already inverted.
   assign alu_n = alu_res[WIDTH-1];
   assign alu_z = (alu_res == '0);
   assign alu_c = is_arith & sum[WIDTH];
   assign alu_v = is_arith & (add_x[WIDTH-1] == add_y[WIDTH-1])
                           & (sum[WIDTH-1] != add_x[WIDTH-1]);

   assign fdr_d = bus.FRLd ? {alu_n, alu_z, alu_c, alu_v} : fdr_q;
   assign ir_d  = bus.IRLd ? bus.ir_in : ir_q;

   always_ff @(posedge CLK) begin
      if (CLR) begin
         fdr_q <= '0;
         ir_q  <= '0;
      end else begin
         fdr_q <= fdr_d;
         ir_q  <= ir_d;
      end
   end

   assign bus.result = alu_res;
   assign bus.flag_n = alu_n;
   assign bus.flag_z = alu_z;
   assign bus.flag_c = alu_c;
   assign bus.flag_v = alu_v;
   assign bus.fdr_q  = fdr_q;
   assign bus.ir_q   = ir_q;
endmodule

// File: tb/tb_alu_flag_ir_unit.sv
// Self-checking bench: directed vectors from the plan plus randomized traffic
// compared against an integer-arithmetic reference model.
module tb_alu_flag_ir_unit;
   logic clk;
   logic clr;
   int   checks;
   int   errors;

   logic [3:0]  fdr_m;
   logic [31:0] ir_m;

   typedef struct packed {
      logic [31:0] res;
      logic [3:0]  nzcv;
   } alu_ref_t;

   alu_flag_ir_unit_if #(.WIDTH(32)) bus ();

   alu_flag_ir_unit #(.WIDTH(32)) dut (
      .CLK (clk),
      .CLR (clr),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed %08h expected %08h", tag, obs, exp);
      end
   endtask

   function automatic logic ovf(input longint sv);
      return (sv > 64'sd2147483647) || (sv < -64'sd2147483648);
   endfunction

   function automatic alu_ref_t finish_ref(input longint full, input logic c, input logic v);
      alu_ref_t r;
      r.res  = full[31:0];
      r.nzcv = {r.res[31], r.res == 32'd0, c, v};
      return r;
   endfunction

   function automatic alu_ref_t add_ref(input logic [31:0] x, input logic [31:0] y, input logic k);
      longint ux, uy, sx, sy, full;
      ux = longint'(x);
      uy = longint'(y);
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      full = ux + uy + longint'(k);
      return finish_ref(full, full > 64'sd4294967295, ovf(sx + sy + longint'(k)));
   endfunction

   // x - y - bw; carry is "no unsigned borrow"
   function automatic alu_ref_t sub_ref(input logic [31:0] x, input logic [31:0] y, input logic bw);
      longint ux, uy, sx, sy, full;
      ux = longint'(x);
      uy = longint'(y);
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      full = ux - uy - longint'(bw);
      return finish_ref(full, ux >= uy + longint'(bw), ovf(sx - sy - longint'(bw)));
   endfunction

   function automatic alu_ref_t ref_alu(input logic [4:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic cin);
      case (op)
         5'd0, 5'd8:  return finish_ref(longint'(a & b), 1'b0, 1'b0);
         5'd1, 5'd9:  return finish_ref(longint'(a ^ b), 1'b0, 1'b0);
         5'd2, 5'd10: return sub_ref(a, b, 1'b0);
         5'd3:        return sub_ref(b, a, 1'b0);
         5'd4, 5'd11: return add_ref(a, b, 1'b0);
         5'd5:        return add_ref(a, b, cin);
         5'd6:        return sub_ref(a, b, !cin);
         5'd7:        return sub_ref(b, a, !cin);
         5'd12:       return finish_ref(longint'(a | b), 1'b0, 1'b0);
         5'd13:       return finish_ref(longint'(b), 1'b0, 1'b0);
         5'd14:       return finish_ref(longint'(a & ~b), 1'b0, 1'b0);
         5'd15:       return finish_ref(longint'(~b), 1'b0, 1'b0);
         5'd16:       return finish_ref(longint'(a), 1'b0, 1'b0);
         5'd17:       return add_ref(a, 32'd4, 1'b0);
         5'd18:       return add_ref(b, 32'd4, 1'b0);
         5'd19:       return sub_ref(a, 32'd4, 1'b0);
         default:     return '{res: 32'd0, nzcv: 4'b0100};
      endcase
   endfunction

   task automatic drive(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic cin, input logic frld, input logic irld, input logic [31:0] irin);
      bus.op       = op;
      bus.A        = a;
      bus.B        = b;
      bus.carry_in = cin;
      bus.FRLd     = frld;
      bus.IRLd     = irld;
      bus.ir_in    = irin;
   endtask

   task automatic check_alu_model(input string tag);
      alu_ref_t r;
      #1;
      r = ref_alu(bus.op, bus.A, bus.B, bus.carry_in);
      check_value({tag, "_res"}, bus.result, r.res);
      check_value({tag, "_nzcv"}, 32'({bus.flag_n, bus.flag_z, bus.flag_c, bus.flag_v}), 32'(r.nzcv));
   endtask

   task automatic check_alu_const(input string tag, input logic [31:0] res, input logic [3:0] nzcv);
      #1;
      check_value({tag, "_res"}, bus.result, res);
      check_value({tag, "_nzcv"}, 32'({bus.flag_n, bus.flag_z, bus.flag_c, bus.flag_v}), 32'(nzcv));
      $display("txn %s op=%05b A=%08h B=%08h res=%08h", tag, bus.op, bus.A, bus.B, bus.result);
   endtask

   // Update the register model from what is presented, then clock and compare.
   task automatic clock_edge(input string tag);
      alu_ref_t r;
      r = ref_alu(bus.op, bus.A, bus.B, bus.carry_in);
      if (clr) begin
         fdr_m = 4'd0;
         ir_m  = 32'd0;
      end else begin
         if (bus.FRLd) fdr_m = r.nzcv;
         if (bus.IRLd) ir_m  = bus.ir_in;
      end
      @(posedge clk);
      #1;
      check_value({tag, "_fdr"}, 32'(bus.fdr_q), 32'(fdr_m));
      check_value({tag, "_ir"}, bus.ir_q, ir_m);
   endtask

   logic [31:0] edge_vals [8];

   initial begin
      checks = 0;
      errors = 0;
      fdr_m  = 4'd0;
      ir_m   = 32'd0;
      edge_vals = '{32'h0, 32'h1, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF,
                    32'hFFFFFFFC, 32'h4, 32'h80000001};

      // Reset wins over both load enables
      clr = 1'b1;
      drive(5'd4, 32'h1, 32'h2, 1'b0, 1'b1, 1'b1, 32'hE3A01005);
      @(posedge clk);
      #1;
      check_value("rst_ir", bus.ir_q, 32'h0);
      check_value("rst_fdr", 32'(bus.fdr_q), 32'h0);
      $display("txn reset ir=%08h fdr=%04b", bus.ir_q, bus.fdr_q);
      clr = 1'b0;
      drive(5'd4, 32'h1, 32'h2, 1'b0, 1'b0, 1'b1, 32'hE3A01005);
      @(posedge clk);
      #1;
      check_value("ir_load", bus.ir_q, 32'hE3A01005);
      ir_m = 32'hE3A01005;

      drive(5'd4, 32'h7FFFFFFF, 32'h1, 1'b0, 1'b1, 1'b0, 32'h0);
      check_alu_const("add_ovf", 32'h80000000, 4'b1001);
      @(posedge clk);
      #1;
      check_value("add_ovf_fdr", 32'(bus.fdr_q), 32'(4'b1001));
      fdr_m = 4'b1001;

      drive(5'd4, 32'hFFFFFFFF, 32'h1, 1'b0, 1'b0, 1'b0, 32'h0);
      check_alu_const("add_carry", 32'h0, 4'b0110);
      drive(5'd10, 32'h5, 32'h5, 1'b0, 1'b0, 1'b0, 32'h0);
      check_alu_const("cmp_eq", 32'h0, 4'b0110);
      drive(5'd2, 32'h3, 32'h5, 1'b0, 1'b0, 1'b0, 32'h0);
      check_alu_const("sub_borrow", 32'hFFFFFFFE, 4'b1000);
      drive(5'd5, 32'h1, 32'h1, 1'b1, 1'b0, 1'b0, 32'h0);
      check_alu_const("adc", 32'h3, 4'b0000);
      drive(5'd3, 32'h2, 32'h7, 1'b0, 1'b0, 1'b0, 32'h0);
      check_alu_const("rsb", 32'h5, 4'b0010);
      drive(5'd6, 32'h5, 32'h3, 1'b0, 1'b0, 1'b0, 32'h0);
      check_alu_const("sbc", 32'h1, 4'b0010);
      drive(5'd0, 32'hF0F0F0F0, 32'hFF00FF00, 1'b1, 1'b0, 1'b0, 32'h0);
      check_alu_const("and", 32'hF000F000, 4'b1000);
      drive(5'd14, 32'hF0F0F0F0, 32'hFF00FF00, 1'b1, 1'b0, 1'b0, 32'h0);
      check_alu_const("bic", 32'h00F000F0, 4'b0000);
      drive(5'd15, 32'h12345678, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
      check_alu_const("mvn", 32'hFFFFFFFF, 4'b1000);
      drive(5'd17, 32'h98, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
      check_alu_const("a_plus4", 32'h9C, 4'b0000);
      drive(5'd19, 32'h2, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
      check_alu_const("a_minus4", 32'hFFFFFFFE, 4'b1000);
      drive(5'd31, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 32'h0);
      check_alu_const("reserved", 32'h0, 4'b0100);

      // Hold: registers keep their value while everything else moves
      for (int i = 0; i < 3; i++) begin
         drive(5'($urandom_range(19, 0)), $urandom, $urandom, 1'($urandom), 1'b0, 1'b0, $urandom);
         clock_edge("hold");
         $display("txn hold %0d fdr=%04b ir=%08h", i, bus.fdr_q, bus.ir_q);
      end

      for (int i = 0; i < 300; i++) begin
         logic [31:0] a, b;
         a = ($urandom_range(3, 0) == 0) ? edge_vals[$urandom_range(7, 0)] : $urandom;
         b = ($urandom_range(3, 0) == 0) ? edge_vals[$urandom_range(7, 0)] : $urandom;
         clr = ($urandom_range(31, 0) == 0);
         drive(5'($urandom_range(31, 0)), a, b, 1'($urandom), 1'($urandom), 1'($urandom), $urandom);
         check_alu_model("rand");
         $display("txn rand %0d op=%05b A=%08h B=%08h cin=%0b res=%08h", i, bus.op, bus.A, bus.B,
                  bus.carry_in, bus.result);
         clock_edge("rand");
      end
      clr = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/alu_flag_ir_unit.md
Name: alu_flag_ir_unit

Overview:
Execution core slice of the 32-bit ARM-style multicycle CPU datapath. It contains three parts:
- a combinational 32-bit ALU with 5-bit opcode and N/Z/C/V flag generation;
- a 4-bit flag register (FDR) that captures ALU flags on FRLd;
- a 32-bit instruction register (IR) that captures the memory data word on IRLd.
The control unit drives the load enables; the condition tester consumes the FDR output and IR[31:28].

Parameters:
WIDTH, 32, datapath width of A, B, result and IR

Ports:
CLK  input  1  clock; all state updates on rising edge
CLR  input  1  reset, synchronous, active-high; clears FDR and IR
A  input  32  ALU operand A (register-file port A)
B  input  32  ALU operand B (mux B output)
op  input  5  ALU opcode
carry_in  input  1  carry input for ADC/SBC/RSC
FRLd  input  1  flag register load enable
IRLd  input  1  instruction register load enable
ir_in  input  32  instruction word from memory data out
result  output  32  ALU result (combinational)
flag_n, flag_z, flag_c, flag_v  output  1 each  combinational ALU flags
fdr_q  output  4  registered flags {N,Z,C,V}
ir_q  output  32  registered instruction

Behaviour:
ALU is purely combinational. In the opcode list, "cin" means carry_in. Opcodes:
- 00000 AND A&B
- 00001 EOR A^B
- 00010 SUB A-B
- 00011 RSB B-A
- 00100 ADD A+B
- 00101 ADC A+B+cin
- 00110 SBC A-B-!cin
- 00111 RSC B-A-!cin
- 01000 TST A&B
- 01001 TEQ A^B
- 01010 CMP A-B
- 01011 CMN A+B
- 01100 ORR A|B
- 01101 MOV B
- 01110 BIC A&~B
- 01111 MVN ~B
- 10000 PASS A
- 10001 A+4
- 10010 B+4
- 10011 A-4
- 10100..11111 reserved: result 0, Z=1, N=C=V=0.

Flag rules:
- TST/TEQ/CMP/CMN still drive result with the computed value; register write suppression belongs to the control unit.
- N = result[31]; Z = (result == 0), for all defined opcodes.
- Add-type (ADD, ADC, CMN, A+4, B+4): C = carry out of bit 31 from a 33-bit sum. V = operands have the same sign and the result sign differs.
- Subtract-type (SUB, SBC, CMP, RSB, RSC, A-4): C = NOT borrow, i.e. C=1 when there is no unsigned borrow. V = operands have different signs and the result sign differs from the minuend.
- Logical/move/pass ops: C=0, V=0.
- Arithmetic wraps modulo 2^32.

FDR:
- Rising CLK: if CLR, fdr_q <= 0.
- Else if FRLd, fdr_q <= {flag_n, flag_z, flag_c, flag_v} of the current cycle.
- Else hold.

IR:
- Rising CLK: if CLR, ir_q <= 0.
- Else if IRLd, ir_q <= ir_in.
- Else hold.

Timing and priority:
- CLR has priority over the load enables on the same edge.
- Both registers are 0 after reset.
- Load latency is one edge; new values are visible after the rising edge.
- FRLd and IRLd are independent and may be asserted simultaneously.
- ALU outputs track inputs with zero latency and no clock dependence.

Test Plan:
- Reset: CLR=1, FRLd=1, IRLd=1, ir_in=E3A01005, one edge -> ir_q=00000000, fdr_q=0000. Release CLR, IRLd=1, one edge -> ir_q=E3A01005.
- ADD overflow: op=00100, A=7FFFFFFF, B=00000001 -> result=80000000, N=1 Z=0 C=0 V=1. FRLd=1 edge -> fdr_q=1001.
- ADD carry/zero: op=00100, A=FFFFFFFF, B=00000001 -> result=0, N=0 Z=1 C=1 V=0. CMP: op=01010, A=5, B=5 -> result=0, Z=1, C=1.
- SUB borrow: op=00010, A=3, B=5 -> result=FFFFFFFE, N=1 C=0 V=0. ADC: op=00101, A=1, B=1, carry_in=1 -> result=3. RSB: op=00011, A=2, B=7 -> result=5.
- Logical/pass: AND F0F0F0F0 & FF00FF00 -> F000F000, C=V=0. BIC -> 00F000F0. MVN B=0 -> FFFFFFFF, N=1. A+4 with A=00000098 -> 0000009C. Reserved op=11111 -> result=0, Z=1.
- Hold: FRLd=0, IRLd=0 while ALU inputs and ir_in change for 3 edges -> fdr_q and ir_q unchanged.
